// File: rtl/iob_fifo_pkg.sv
// iob_fifo_pkg
//   Shared width arithmetic for the asymmetric FIFOs (sync and async).
//   The narrow width is min(W_DATA_W, R_DATA_W). RATIO is max/min and is
//   a power of two. The wide side addresses whole wide words, so its
//   address is RATIO_W bits shorter than the narrow-side address.
package iob_fifo_pkg;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int ratio(input int w_data_w, input int r_data_w);
    return max_w(w_data_w, r_data_w) / min_w(w_data_w, r_data_w);
  endfunction

  function automatic int ratio_w(input int w_data_w, input int r_data_w);
    return $clog2(ratio(w_data_w, r_data_w));
  endfunction

  // Write-side address width: shortened only when the write side is wide.
  function automatic int w_addr_w(input int w_data_w, input int r_data_w, input int addr_w);
    return (w_data_w > r_data_w) ? addr_w - ratio_w(w_data_w, r_data_w) : addr_w;
  endfunction

  // Read-side address width: shortened only when the read side is wide.
  function automatic int r_addr_w(input int w_data_w, input int r_data_w, input int addr_w);
    return (r_data_w > w_data_w) ? addr_w - ratio_w(w_data_w, r_data_w) : addr_w;
  endfunction

endpackage

// File: rtl/iob_fifo_sync_asym_if.sv
// iob_fifo_sync_asym_if
//   Handshake and status bundle of the single-clock asymmetric FIFO.
//   master: the producer/consumer side (drives w_en, w_data, r_en and,
//           when IOB_FIFO_SYNC_ASYM_THRESH_EN is defined, the thresholds).
//   slave:  the FIFO itself (drives full, empty, levels, r_data and,
//           when IOB_FIFO_SYNC_ASYM_THRESH_EN is defined, almost_full
//           and almost_empty).
//   Parameters must match those of the attached iob_fifo_sync_asym.
interface iob_fifo_sync_asym_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 8
);
  localparam int W_ADDR_W = iob_fifo_pkg::w_addr_w(W_DATA_W, R_DATA_W, ADDR_W);
  localparam int R_ADDR_W = iob_fifo_pkg::r_addr_w(W_DATA_W, R_DATA_W, ADDR_W);

  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                full;
  logic [W_ADDR_W:0]   level_w;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                empty;
  logic [R_ADDR_W:0]   level_r;
  logic [ADDR_W:0]     level_n;
`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
  logic [W_ADDR_W:0]   af_thresh;
  logic [R_ADDR_W:0]   ae_thresh;
  logic                almost_full;
  logic                almost_empty;

  modport master (
    output w_en, w_data, r_en, af_thresh, ae_thresh,
    input  full, level_w, r_data, empty, level_r, level_n, almost_full, almost_empty
  );

  modport slave (
    input  w_en, w_data, r_en, af_thresh, ae_thresh,
    output full, level_w, r_data, empty, level_r, level_n, almost_full, almost_empty
  );
`else
  modport master (
    output w_en, w_data, r_en,
    input  full, level_w, r_data, empty, level_r, level_n
  );

  modport slave (
    input  w_en, w_data, r_en,
    output full, level_w, r_data, empty, level_r, level_n
  );
`endif

endinterface

// File: rtl/iob_ram_2p_asym.sv
// iob_ram_2p_asym
//   Single-clock two-port RAM with different write and read widths.
//   Storage is an array of narrow words; a wide port touches RATIO
//   consecutive narrow words, lowest address in the least significant
//   slice (little-endian).
//   Ports:
//     clk, rst          clock; async active-high reset (read register only)
//     w_en/w_addr/w_data write port, address in write-word units
//     r_en/r_addr/r_data read port, address in read-word units,
//                        registered output that holds between reads
//   Memory contents are never cleared.
module iob_ram_2p_asym import iob_fifo_pkg::*; #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 8,
  parameter int W_ADDR_W = w_addr_w(W_DATA_W, R_DATA_W, ADDR_W),
  parameter int R_ADDR_W = r_addr_w(W_DATA_W, R_DATA_W, ADDR_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_ADDR_W-1:0] w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [R_ADDR_W-1:0] r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int N     = min_w(W_DATA_W, R_DATA_W);
  localparam int WS    = W_DATA_W / N;
  localparam int RS    = R_DATA_W / N;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0] mem [DEPTH];

  // Narrow slice i of a wide write lands at narrow address w_addr*WS + i.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < WS; i++) begin
        mem[ADDR_W'(int'(w_addr) * WS + i)] <= w_data[i*N +: N];
      end
    end
  end

  // Read register clears on reset so stale data never appears after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_en) begin
      for (int i = 0; i < RS; i++) begin
        r_data[i*N +: N] <= mem[ADDR_W'(int'(r_addr) * RS + i)];
      end
    end
  end

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// iob_fifo_sync_asym
//   Single-clock FIFO with power-of-two-related write and read widths.
//   Narrow writes are packed into wide reads, or wide writes unpacked into
//   narrow reads, little-endian. Holds the full 2^ADDR_W narrow words.
//   Ports:
//     clk   clock
//     rst   asynchronous reset, active-high
//     bus   iob_fifo_sync_asym_if.slave: w_en/w_data/full/level_w,
//           r_en/r_data/empty/level_r, level_n
//   Optional feature: define IOB_FIFO_SYNC_ASYM_THRESH_EN to add
//   af_thresh/ae_thresh inputs and almost_full/almost_empty outputs.
module iob_fifo_sync_asym import iob_fifo_pkg::*; #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  iob_fifo_sync_asym_if.slave  bus
);

  localparam int N        = min_w(W_DATA_W, R_DATA_W);
  localparam int RATIO    = ratio(W_DATA_W, R_DATA_W);
  localparam int RATIO_W  = $clog2(RATIO);
  localparam int W_ADDR_W = w_addr_w(W_DATA_W, R_DATA_W, ADDR_W);
  localparam int R_ADDR_W = r_addr_w(W_DATA_W, R_DATA_W, ADDR_W);
  localparam int WS       = W_DATA_W / N;
  localparam int RS       = R_DATA_W / N;
  localparam int W_SHIFT  = (W_DATA_W > R_DATA_W) ? RATIO_W : 0;
  localparam int R_SHIFT  = (R_DATA_W > W_DATA_W) ? RATIO_W : 0;

  localparam logic [ADDR_W:0] CAP    = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] WS_CNT = (ADDR_W+1)'(WS);
  localparam logic [ADDR_W:0] RS_CNT = (ADDR_W+1)'(RS);

  // Pointers count whole port words. The narrow-unit pointer is ptr*WS (or
  // ptr*RS); its low RATIO_W bits are always zero on a wide side, so they
  // are not stored.
  logic [W_ADDR_W-1:0] wptr;
  logic [R_ADDR_W-1:0] rptr;
  logic [ADDR_W:0]     cnt;

  logic              full_i;
  logic              empty_i;
  logic              w_acc;
  logic              r_acc;
  logic [W_ADDR_W:0] level_w_i;
  logic [R_ADDR_W:0] level_r_i;

  // Accept decisions use the current-cycle status only, so a read in the
  // same cycle never frees space for a write that arrives while full.
  always_comb begin
    full_i    = (CAP - cnt) < WS_CNT;
    empty_i   = cnt < RS_CNT;
    w_acc     = bus.w_en & ~full_i;
    r_acc     = bus.r_en & ~empty_i;
    level_w_i = (W_ADDR_W+1)'(cnt >> W_SHIFT);
    level_r_i = (R_ADDR_W+1)'(cnt >> R_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (w_acc) begin
        wptr <= wptr + W_ADDR_W'(1);
      end
      if (r_acc) begin
        rptr <= rptr + R_ADDR_W'(1);
      end
      cnt <= cnt + (w_acc ? WS_CNT : '0) - (r_acc ? RS_CNT : '0);
    end
  end

  iob_ram_2p_asym #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W),
    .W_ADDR_W (W_ADDR_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_acc),
    .w_addr (wptr),
    .w_data (bus.w_data),
    .r_en   (r_acc),
    .r_addr (rptr),
    .r_data (bus.r_data)
  );

  assign bus.full    = full_i;
  assign bus.empty   = empty_i;
  assign bus.level_w = level_w_i;
  assign bus.level_r = level_r_i;
  assign bus.level_n = cnt;

`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
  assign bus.almost_full  = level_w_i >= bus.af_thresh;
  assign bus.almost_empty = level_r_i <= bus.ae_thresh;
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// tb_iob_fifo_sync_asym
//   Directed self-checking bench for iob_fifo_sync_asym. Three instances:
//   u_pack (W=8, R=32, ADDR_W=4), u_unpack (W=32, R=8, ADDR_W=4) and, when
//   IOB_FIFO_SYNC_ASYM_THRESH_EN is defined, u_thr (W=R=8, ADDR_W=4).
module tb_iob_fifo_sync_asym;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  iob_fifo_sync_asym_if #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) a_if ();
  iob_fifo_sync_asym_if #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) b_if ();

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_pack (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_unpack (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
  iob_fifo_sync_asym_if #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4)) c_if ();

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4)) u_thr (
    .clk (clk),
    .rst (rst),
    .bus (c_if)
  );
`endif

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_if.w_en   = 1'b1;
    a_if.w_data = d;
    tick();
    a_if.w_en   = 1'b0;
  endtask

  task automatic pop_a();
    a_if.r_en = 1'b1;
    tick();
    a_if.r_en = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] d);
    b_if.w_en   = 1'b1;
    b_if.w_data = d;
    tick();
    b_if.w_en   = 1'b0;
  endtask

  task automatic pop_b();
    b_if.r_en = 1'b1;
    tick();
    b_if.r_en = 1'b0;
  endtask

`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
  task automatic push_c(input logic [7:0] d);
    c_if.w_en   = 1'b1;
    c_if.w_data = d;
    tick();
    c_if.w_en   = 1'b0;
  endtask
`endif

  initial begin
    logic [7:0]  pat;
    logic [31:0] exp_word;

    a_if.w_en = 1'b0; a_if.w_data = '0; a_if.r_en = 1'b0;
    b_if.w_en = 1'b0; b_if.w_data = '0; b_if.r_en = 1'b0;
`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
    c_if.w_en = 1'b0; c_if.w_data = '0; c_if.r_en = 1'b0;
    c_if.af_thresh = 5'd3;
    c_if.ae_thresh = 5'd1;
`endif

    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    checkOutput("rst_empty",   a_if.empty,   1);
    checkOutput("rst_full",    a_if.full,    0);
    checkOutput("rst_level_n", a_if.level_n, 0);
    checkOutput("rst_level_r", a_if.level_r, 0);
    checkOutput("rst_level_w", a_if.level_w, 0);
    checkOutput("rst_r_data",  a_if.r_data,  0);
    checkOutput("rst_b_empty", b_if.empty,   1);

    // Packing: empty stays high until four bytes form one read word
    push_a(8'h11);
    checkOutput("pack_empty1", a_if.empty, 1);
    push_a(8'h22);
    checkOutput("pack_empty2", a_if.empty, 1);
    push_a(8'h33);
    checkOutput("pack_empty3", a_if.empty, 1);
    push_a(8'h44);
    checkOutput("pack_empty4", a_if.empty,   0);
    checkOutput("pack_lvl_n",  a_if.level_n, 4);
    checkOutput("pack_lvl_r",  a_if.level_r, 1);
    checkOutput("pack_lvl_w",  a_if.level_w, 4);
    pop_a();
    checkOutput("pack_rdata",  a_if.r_data,  32'h4433_2211);
    checkOutput("pack_empty5", a_if.empty,   1);

    // Unpacking: one wide write yields four bytes, LSB first
    push_b(32'hA1B2_C3D4);
    checkOutput("unpack_lvl_r", b_if.level_r, 4);
    checkOutput("unpack_lvl_w", b_if.level_w, 1);
    pop_b();
    checkOutput("unpack_r0", b_if.r_data, 32'hD4);
    pop_b();
    checkOutput("unpack_r1", b_if.r_data, 32'hC3);
    pop_b();
    checkOutput("unpack_r2", b_if.r_data, 32'hB2);
    pop_b();
    checkOutput("unpack_r3", b_if.r_data, 32'hA1);
    checkOutput("unpack_empty", b_if.empty, 1);

    // Fill with bytes 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      push_a(8'(i));
    end
    checkOutput("fill_full",  a_if.full,    1);
    checkOutput("fill_lvl_n", a_if.level_n, 16);
    checkOutput("fill_lvl_r", a_if.level_r, 4);
    push_a(8'hFF);
    checkOutput("fill_17th_lvl_n", a_if.level_n, 16);
    checkOutput("fill_17th_full",  a_if.full,    1);

    // Write+read at full: read accepted, write rejected (16-4=12).
    // Next cycle both accepted: +1 narrow in, -4 narrow out -> 9.
    a_if.w_en   = 1'b1;
    a_if.w_data = 8'h11;
    a_if.r_en   = 1'b1;
    tick();
    checkOutput("wr_full_lvl_n", a_if.level_n, 12);
    checkOutput("wr_full_rdata", a_if.r_data,  32'h0403_0201);
    checkOutput("wr_full_full",  a_if.full,    0);
    tick();
    checkOutput("wr_both_lvl_n", a_if.level_n, 9);
    checkOutput("wr_both_rdata", a_if.r_data,  32'h0807_0605);
    a_if.w_en = 1'b0;
    a_if.r_en = 1'b0;
    pop_a();
    checkOutput("drain_r2", a_if.r_data, 32'h0C0B_0A09);
    pop_a();
    checkOutput("drain_r3", a_if.r_data, 32'h100F_0E0D);
    checkOutput("drain_empty", a_if.empty,   1);
    checkOutput("drain_lvl_n", a_if.level_n, 1);
    // A read while empty must leave r_data untouched
    pop_a();
    checkOutput("empty_rd_hold", a_if.r_data,  32'h100F_0E0D);
    checkOutput("empty_rd_lvl",  a_if.level_n, 1);
    push_a(8'h12);
    push_a(8'h13);
    push_a(8'h14);
    pop_a();
    checkOutput("drain_r4", a_if.r_data, 32'h1413_1211);
    checkOutput("drain_lvl_n0", a_if.level_n, 0);

    // Wrap: three fill/drain rounds with an incrementing byte pattern
    pat = 8'h20;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) begin
        push_a(pat + 8'(i));
      end
      checkOutput("wrap_full", a_if.full, 1);
      for (int w = 0; w < 4; w++) begin
        for (int k = 0; k < 4; k++) begin
          exp_word[k*8 +: 8] = pat + 8'(4 * w + k);
        end
        pop_a();
        checkOutput("wrap_data", a_if.r_data, exp_word);
      end
      pat = pat + 8'd16;
    end
    checkOutput("wrap_lvl_n", a_if.level_n, 0);
    checkOutput("wrap_empty", a_if.empty,   1);

    // Reset mid-fill clears status and r_data immediately
    push_a(8'hA0);
    push_a(8'hA1);
    push_a(8'hA2);
    push_a(8'hA3);
    pop_a();
    checkOutput("pre_rst_rdata", a_if.r_data, 32'hA3A2_A1A0);
    push_a(8'hB0);
    push_a(8'hB1);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_empty", a_if.empty,   1);
    checkOutput("mid_rst_lvl_n", a_if.level_n, 0);
    checkOutput("mid_rst_rdata", a_if.r_data,  0);
    tick();
    rst = 1'b0;
    push_a(8'hC0);
    push_a(8'hC1);
    push_a(8'hC2);
    push_a(8'hC3);
    pop_a();
    checkOutput("post_rst_rdata", a_if.r_data, 32'hC3C2_C1C0);

`ifdef IOB_FIFO_SYNC_ASYM_THRESH_EN
    // Thresholds af=3, ae=1 on an 8/8 FIFO
    checkOutput("thr_rst_ae", c_if.almost_empty, 1);
    checkOutput("thr_rst_af", c_if.almost_full,  0);
    push_c(8'h01);
    checkOutput("thr_l1_ae", c_if.almost_empty, 1);
    checkOutput("thr_l1_af", c_if.almost_full,  0);
    push_c(8'h02);
    checkOutput("thr_l2_ae", c_if.almost_empty, 0);
    checkOutput("thr_l2_af", c_if.almost_full,  0);
    push_c(8'h03);
    checkOutput("thr_l3_af", c_if.almost_full,  1);
    checkOutput("thr_l3_ae", c_if.almost_empty, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
